// File: rtl/bp_fe_lce_req_mshr.sv
// Front-end LCE request MSHR: tracks outstanding miss / uncached requests from issue through ack.
// Optional blocked-cycle timeout enabled by defining BP_FE_LCE_REQ_TIMEOUT_EN.
module bp_fe_lce_req_mshr #(
  parameter int unsigned num_mshr_p           = 2,
  parameter int unsigned paddr_width_p        = 40,
  parameter int unsigned lce_id_width_p       = 4,
  parameter int unsigned way_width_p          = 3,
  parameter int unsigned dword_width_p        = 64,
  parameter int unsigned block_offset_width_p = 6,
  parameter int unsigned timeout_max_limit_p  = 4,
  localparam int unsigned IdW = (num_mshr_p > 1) ? $clog2(num_mshr_p) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [lce_id_width_p-1:0] lce_id_i,

  input  logic                      cache_req_v_i,
  output logic                      cache_req_ready_o,
  input  logic [1:0]                cache_req_type_i,
  input  logic [paddr_width_p-1:0]  cache_req_addr_i,
  input  logic [way_width_p-1:0]    cache_req_way_i,
  input  logic [dword_width_p-1:0]  cache_req_data_i,

  output logic                      lce_req_v_o,
  input  logic                      lce_req_ready_i,
  output logic [1:0]                lce_req_type_o,
  output logic [paddr_width_p-1:0]  lce_req_addr_o,
  output logic [way_width_p-1:0]    lce_req_way_o,
  output logic [dword_width_p-1:0]  lce_req_data_o,
  output logic [IdW-1:0]            lce_req_id_o,
  output logic [lce_id_width_p-1:0] lce_req_src_o,

  input  logic                      data_rcv_v_i,
  input  logic [IdW-1:0]            data_rcv_id_i,
  input  logic                      set_tag_rcv_v_i,
  input  logic [IdW-1:0]            set_tag_rcv_id_i,
  input  logic                      uc_done_v_i,
  input  logic [IdW-1:0]            uc_done_id_i,

  output logic                      lce_resp_v_o,
  input  logic                      lce_resp_yumi_i,
  output logic [paddr_width_p-1:0]  lce_resp_addr_o,

  input  logic                      coherence_blocked_i,
  output logic                      mshr_empty_o
);

  typedef enum logic [1:0] {StFree, StSend, StWait, StAck} ent_state_e;
  localparam logic [1:0] ReqMiss    = 2'd0;
  localparam logic [1:0] ReqUcLoad  = 2'd1;
  localparam logic [1:0] ReqUcStore = 2'd2;
  localparam logic [1:0] ReqRsvd    = 2'd3;
  localparam int unsigned TagW = paddr_width_p - block_offset_width_p;

  ent_state_e                state_q [num_mshr_p];
  ent_state_e                state_d [num_mshr_p];
  logic [num_mshr_p-1:0]     data_r_q, data_r_d, tag_r_q, tag_r_d;
  logic [1:0]                type_q  [num_mshr_p];
  logic [paddr_width_p-1:0]  addr_q  [num_mshr_p];
  logic [way_width_p-1:0]    way_q   [num_mshr_p];
  logic [dword_width_p-1:0]  wdata_q [num_mshr_p];

  logic           free_found, send_found, ack_found, dup_hit, timeout_active;
  logic [IdW-1:0] free_idx, send_idx, ack_idx;
  logic           alloc, req_fire, resp_fire;

`ifdef BP_FE_LCE_REQ_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(timeout_max_limit_p + 1);
  logic [CntW-1:0] timeout_cnt_q, timeout_cnt_d;

  // Saturates at the limit so the block persists for as long as starvation does.
  always_comb begin
    timeout_cnt_d = '0;
    if (coherence_blocked_i) begin
      timeout_cnt_d = (timeout_cnt_q == CntW'(timeout_max_limit_p)) ? timeout_cnt_q
                                                                    : timeout_cnt_q + 1'b1;
    end
    timeout_active = coherence_blocked_i
                     && ((int'(timeout_cnt_q) + 1) >= int'(timeout_max_limit_p));
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) timeout_cnt_q <= '0;
    else            timeout_cnt_q <= timeout_cnt_d;
  end
`else
  logic unused_coherence_blocked;
  assign unused_coherence_blocked = coherence_blocked_i;
  assign timeout_active = 1'b0;
`endif

  // Lowest-index search: scanning downwards lets the last hit win.
  always_comb begin
    free_found = 1'b0;
    send_found = 1'b0;
    ack_found  = 1'b0;
    dup_hit    = 1'b0;
    free_idx   = '0;
    send_idx   = '0;
    ack_idx    = '0;
    for (int i = int'(num_mshr_p) - 1; i >= 0; i--) begin
      if (state_q[i] == StFree) begin
        free_found = 1'b1;
        free_idx   = IdW'(i);
      end
      if (state_q[i] == StSend) begin
        send_found = 1'b1;
        send_idx   = IdW'(i);
      end
      if (state_q[i] == StAck) begin
        ack_found = 1'b1;
        ack_idx   = IdW'(i);
      end
      if ((state_q[i] != StFree) && (addr_q[i][paddr_width_p-1 -: TagW]
                                     == cache_req_addr_i[paddr_width_p-1 -: TagW])) begin
        dup_hit = 1'b1;
      end
    end
  end

  // Output process.
  always_comb begin
    cache_req_ready_o = reset_n_i & free_found & ~dup_hit & ~timeout_active;
    lce_req_v_o       = reset_n_i & send_found;
    lce_req_id_o      = send_idx;
    lce_req_type_o    = type_q[send_idx];
    lce_req_way_o     = way_q[send_idx];
    lce_req_src_o     = lce_id_i;
    lce_req_addr_o    = addr_q[send_idx];
    if (type_q[send_idx] == ReqUcLoad) lce_req_addr_o[2:0] = 3'b000;
    lce_req_data_o    = (type_q[send_idx] == ReqUcStore) ? wdata_q[send_idx] : '0;
    lce_resp_v_o      = reset_n_i & ack_found;
    lce_resp_addr_o   = addr_q[ack_idx];
    mshr_empty_o      = 1'b1;
    for (int i = 0; i < int'(num_mshr_p); i++) begin
      if (state_q[i] != StFree) mshr_empty_o = 1'b0;
    end
  end

  assign alloc     = cache_req_v_i & cache_req_ready_o & (cache_req_type_i != ReqRsvd);
  assign req_fire  = lce_req_v_o & lce_req_ready_i;
  assign resp_fire = lce_resp_v_o & lce_resp_yumi_i;

  // Next-state process; each event only acts on an entry in its own state.
  always_comb begin
    for (int i = 0; i < int'(num_mshr_p); i++) begin
      state_d[i]  = state_q[i];
      data_r_d[i] = data_r_q[i];
      tag_r_d[i]  = tag_r_q[i];
      unique case (state_q[i])
        StFree: if (alloc && (free_idx == IdW'(i))) begin
          state_d[i]  = StSend;
          data_r_d[i] = 1'b0;
          tag_r_d[i]  = 1'b0;
        end
        StSend: if (req_fire && (send_idx == IdW'(i))) state_d[i] = StWait;
        StWait: begin
          if (type_q[i] == ReqMiss) begin
            data_r_d[i] = data_r_q[i] | (data_rcv_v_i && (data_rcv_id_i == IdW'(i)));
            tag_r_d[i]  = tag_r_q[i] | (set_tag_rcv_v_i && (set_tag_rcv_id_i == IdW'(i)));
            if (data_r_d[i] && tag_r_d[i]) state_d[i] = StAck;
          end else if (uc_done_v_i && (uc_done_id_i == IdW'(i))) begin
            state_d[i] = StFree;
          end
        end
        StAck: if (resp_fire && (ack_idx == IdW'(i))) state_d[i] = StFree;
        default: state_d[i] = StFree;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < int'(num_mshr_p); i++) state_q[i] <= StFree;
      data_r_q <= '0;
      tag_r_q  <= '0;
    end else begin
      for (int i = 0; i < int'(num_mshr_p); i++) state_q[i] <= state_d[i];
      data_r_q <= data_r_d;
      tag_r_q  <= tag_r_d;
    end
  end

  // Payload is only meaningful while the entry is not FREE, so it needs no reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(num_mshr_p); i++) begin
      if (alloc && (free_idx == IdW'(i))) begin
        type_q[i]  <= cache_req_type_i;
        addr_q[i]  <= cache_req_addr_i;
        way_q[i]   <= cache_req_way_i;
        wdata_q[i] <= cache_req_data_i;
      end
    end
  end

endmodule

// File: tb/tb_bp_fe_lce_req_mshr.sv
// Directed, table-driven bench for bp_fe_lce_req_mshr at default parameters.
module tb_bp_fe_lce_req_mshr;
`ifdef BP_FE_LCE_REQ_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [3:0]  lce_id_i;
  logic        cache_req_v_i, cache_req_ready_o;
  logic [1:0]  cache_req_type_i;
  logic [39:0] cache_req_addr_i;
  logic [2:0]  cache_req_way_i;
  logic [63:0] cache_req_data_i;
  logic        lce_req_v_o, lce_req_ready_i;
  logic [1:0]  lce_req_type_o;
  logic [39:0] lce_req_addr_o;
  logic [2:0]  lce_req_way_o;
  logic [63:0] lce_req_data_o;
  logic [0:0]  lce_req_id_o;
  logic [3:0]  lce_req_src_o;
  logic        data_rcv_v_i, set_tag_rcv_v_i, uc_done_v_i;
  logic [0:0]  data_rcv_id_i, set_tag_rcv_id_i, uc_done_id_i;
  logic        lce_resp_v_o, lce_resp_yumi_i;
  logic [39:0] lce_resp_addr_o;
  logic        coherence_blocked_i, mshr_empty_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bp_fe_lce_req_mshr dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .lce_id_i(lce_id_i),
    .cache_req_v_i(cache_req_v_i), .cache_req_ready_o(cache_req_ready_o),
    .cache_req_type_i(cache_req_type_i), .cache_req_addr_i(cache_req_addr_i),
    .cache_req_way_i(cache_req_way_i), .cache_req_data_i(cache_req_data_i),
    .lce_req_v_o(lce_req_v_o), .lce_req_ready_i(lce_req_ready_i),
    .lce_req_type_o(lce_req_type_o), .lce_req_addr_o(lce_req_addr_o),
    .lce_req_way_o(lce_req_way_o), .lce_req_data_o(lce_req_data_o),
    .lce_req_id_o(lce_req_id_o), .lce_req_src_o(lce_req_src_o),
    .data_rcv_v_i(data_rcv_v_i), .data_rcv_id_i(data_rcv_id_i),
    .set_tag_rcv_v_i(set_tag_rcv_v_i), .set_tag_rcv_id_i(set_tag_rcv_id_i),
    .uc_done_v_i(uc_done_v_i), .uc_done_id_i(uc_done_id_i),
    .lce_resp_v_o(lce_resp_v_o), .lce_resp_yumi_i(lce_resp_yumi_i),
    .lce_resp_addr_o(lce_resp_addr_o),
    .coherence_blocked_i(coherence_blocked_i), .mshr_empty_o(mshr_empty_o)
  );

  typedef struct {
    logic rv; logic [1:0] rt; logic [39:0] ra; logic [2:0] rw; logic [63:0] rd; logic lr;
    logic dv; logic did; logic tv; logic tid; logic uv; logic uid; logic y; logic b;
    logic e_rdy; logic e_lv; logic [1:0] e_lt; logic [39:0] e_la; logic [2:0] e_lw;
    logic [63:0] e_ld; logic e_lid; logic e_rv; logic [39:0] e_ra; logic e_emp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
      input logic rv, input logic [1:0] rt, input logic [39:0] ra, input logic [2:0] rw,
      input logic [63:0] rd, input logic lr, input logic dv, input logic did, input logic tv,
      input logic tid, input logic uv, input logic uid, input logic y, input logic b,
      input logic e_rdy, input logic e_lv, input logic [1:0] e_lt, input logic [39:0] e_la,
      input logic [2:0] e_lw, input logic [63:0] e_ld, input logic e_lid, input logic e_rv,
      input logic [39:0] e_ra, input logic e_emp);
    vec_t v;
    v.rv = rv; v.rt = rt; v.ra = ra; v.rw = rw; v.rd = rd; v.lr = lr;
    v.dv = dv; v.did = did; v.tv = tv; v.tid = tid; v.uv = uv; v.uid = uid; v.y = y; v.b = b;
    v.e_rdy = e_rdy; v.e_lv = e_lv; v.e_lt = e_lt; v.e_la = e_la; v.e_lw = e_lw;
    v.e_ld = e_ld; v.e_lid = e_lid; v.e_rv = e_rv; v.e_ra = e_ra; v.e_emp = e_emp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    cache_req_v_i    = v.rv;  cache_req_type_i = v.rt; cache_req_addr_i = v.ra;
    cache_req_way_i  = v.rw;  cache_req_data_i = v.rd; lce_req_ready_i  = v.lr;
    data_rcv_v_i     = v.dv;  data_rcv_id_i    = v.did;
    set_tag_rcv_v_i  = v.tv;  set_tag_rcv_id_i = v.tid;
    uc_done_v_i      = v.uv;  uc_done_id_i     = v.uid;
    lce_resp_yumi_i  = v.y;   coherence_blocked_i = v.b;
  endtask

  task automatic apply(input string tag, input vec_t v);
    drive(v);
    @(negedge clk_i);
    chk({tag, " ready"}, 64'(cache_req_ready_o), 64'(v.e_rdy));
    chk({tag, " lreq_v"}, 64'(lce_req_v_o), 64'(v.e_lv));
    if (v.e_lv) begin
      chk({tag, " lreq_type"}, 64'(lce_req_type_o), 64'(v.e_lt));
      chk({tag, " lreq_addr"}, 64'(lce_req_addr_o), 64'(v.e_la));
      chk({tag, " lreq_way"}, 64'(lce_req_way_o), 64'(v.e_lw));
      chk({tag, " lreq_data"}, lce_req_data_o, v.e_ld);
      chk({tag, " lreq_id"}, 64'(lce_req_id_o), 64'(v.e_lid));
      chk({tag, " lreq_src"}, 64'(lce_req_src_o), 64'h5);
    end
    chk({tag, " resp_v"}, 64'(lce_resp_v_o), 64'(v.e_rv));
    if (v.e_rv) chk({tag, " resp_addr"}, 64'(lce_resp_addr_o), 64'(v.e_ra));
    chk({tag, " empty"}, 64'(mshr_empty_o), 64'(v.e_emp));
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    lce_id_i  = 4'h5;
    reset_n_i = 1'b0;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));

    // Single miss.
    vecs.push_back(mk(1,0,'h8000_0040,2,0,0, 0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 1,1,0,'h8000_0040,2,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0,0,0, 1,1,0,'h8000_0040,2,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,0,0,0,0,0,0, 1,0,0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,1,0,0,0,0,0, 1,0,0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,1,0, 1,0,0,0,0,0,0, 1,'h8000_0040,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0, 0,0,1));
    // Full + duplicate; stray events on a SEND entry; simultaneous events; held resp.
    vecs.push_back(mk(1,0,'h100,1,'h1234,0, 0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0, 0,0,1));
    vecs.push_back(mk(1,0,'h200,0,0,0, 0,0,0,0,0,0,0,0, 1,1,0,'h100,1,0,0, 0,0,0));
    vecs.push_back(mk(1,0,'h108,0,0,1, 1,1,1,1,0,0,0,0, 0,1,0,'h100,1,0,0, 0,0,0));
    vecs.push_back(mk(1,0,'h108,0,0,1, 0,0,0,0,0,0,0,0, 0,1,0,'h200,0,0,1, 0,0,0));
    vecs.push_back(mk(1,0,'h108,0,0,0, 1,0,1,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1,0,'h108,0,0,0, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 1,'h100,0));
    vecs.push_back(mk(1,0,'h108,0,0,0, 0,0,0,0,0,0,1,0, 0,0,0,0,0,0,0, 1,'h100,0));
    vecs.push_back(mk(1,0,'h108,3,0,0, 0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0,0,0, 0,1,0,'h108,3,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,0,1,1,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,1,1,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,1,0, 0,0,0,0,0,0,0, 1,'h108,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,1,0, 1,0,0,0,0,0,0, 1,'h200,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0, 0,0,1));
    // Uncached load/store, then a reserved type that must not allocate.
    vecs.push_back(mk(1,1,'h1004,0,0,0, 0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0, 0,0,1));
    vecs.push_back(mk(1,2,'h2000,0,'hDEAD,1, 0,0,0,0,0,0,0,0, 1,1,1,'h1000,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0,0,0, 0,1,2,'h2000,0,'hDEAD,1, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,1,1,0,0, 0,0,0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,1,0,0,0, 1,0,0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0, 0,0,1));
    vecs.push_back(mk(1,3,'h3000,0,0,0, 0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0, 0,0,1));
    // Blocked cycles: only the 4th consecutive one may drop ready, and only with timeout built in.
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,1, 1,0,0,0,0,0,0, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,1, !ToEn,0,0,0,0,0,0, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0, 0,0,1));
    // Two entries into WAIT ahead of the mid-flight reset.
    vecs.push_back(mk(1,0,'h400,0,0,0, 0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0, 0,0,1));
    vecs.push_back(mk(1,0,'h500,0,0,1, 0,0,0,0,0,0,0,0, 1,1,0,'h400,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0,0,0, 0,1,0,'h500,0,0,1, 0,0,0));

    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("reset ready", 64'(cache_req_ready_o), 64'h0);
    chk("reset lreq_v", 64'(lce_req_v_o), 64'h0);
    chk("reset resp_v", 64'(lce_resp_v_o), 64'h0);
    chk("reset empty", 64'(mshr_empty_o), 64'h1);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;

    foreach (vecs[i]) apply($sformatf("row%0d", i), vecs[i]);

    // Reset with completion events and handshakes pending; nothing may escape.
    reset_n_i = 1'b0;
    drive(mk(1,0,'h600,0,0,1, 1,0,1,0,0,0,1,0, 0,0,0,0,0,0,0, 0,0,0));
    @(negedge clk_i);
    chk("midrst ready", 64'(cache_req_ready_o), 64'h0);
    chk("midrst lreq_v", 64'(lce_req_v_o), 64'h0);
    chk("midrst resp_v", 64'(lce_resp_v_o), 64'h0);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    drive(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0));
    @(negedge clk_i);
    chk("postrst lreq_v", 64'(lce_req_v_o), 64'h0);
    chk("postrst resp_v", 64'(lce_resp_v_o), 64'h0);
    chk("postrst empty", 64'(mshr_empty_o), 64'h1);
    chk("postrst ready", 64'(cache_req_ready_o), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
